// File: rtl/tros_readout_rx.sv
// Receive side of the ring-oscillator counter readout link.
// A start request sends a one-cycle latch_counter pulse together with the
// selected counter index. The returned serial frame is then deserialised:
// a 4-bit header 1010, then LENGTH payload bits, MSB first.
module tros_readout_rx #(
    parameter int LENGTH     = 20,
    parameter int PIPE_DELAY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        sel,
    output logic              latch_counter,
    output logic [1:0]        counter_select,
    input  logic              data_in,
    output logic              busy,
    output logic [LENGTH-1:0] count,
    output logic [1:0]        count_sel,
    output logic              count_valid,
    output logic              hdr_error
);

    localparam int BW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int WW = (PIPE_DELAY > 0) ? $clog2(PIPE_DELAY + 1) : 1;
    localparam logic [3:0]    HDR_PATTERN = 4'b1010;
    localparam logic [BW-1:0] LAST_BIT    = BW'(LENGTH - 1);
    localparam logic [WW-1:0] WAIT_LAST   = WW'((PIPE_DELAY > 0) ? PIPE_DELAY - 1 : 0);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        WAIT  = 3'd2,
        HDR   = 3'd3,
        DATA  = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [BW-1:0]     bit_cnt;
    logic [1:0]        hdr_idx;
    logic [WW-1:0]     wait_cnt;
    logic [LENGTH-1:0] shift;
    logic              hdr_bad;
    logic              last_bit;
    logic              wait_done;

    // Decode helpers: header bits are checked MSB first, so index 0 maps to bit 3.
    always_comb begin
        hdr_bad   = (data_in != HDR_PATTERN[~hdr_idx]);
        last_bit  = (bit_cnt == LAST_BIT);
        wait_done = (wait_cnt == WAIT_LAST);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start outside IDLE is dropped, not queued.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LATCH;
            LATCH:   state_nxt = (PIPE_DELAY == 0) ? HDR : WAIT;
            WAIT:    if (wait_done) state_nxt = HDR;
            HDR: begin
                if (hdr_bad) begin
                    state_nxt = IDLE;
                end else if (hdr_idx == 2'd3) begin
                    state_nxt = DATA;
                end
            end
            DATA:    if (last_bit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        busy = (state != IDLE);
    end

    // Registered outputs, counters and payload shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            latch_counter  <= 1'b0;
            counter_select <= 2'd0;
            count          <= '0;
            count_sel      <= 2'd0;
            count_valid    <= 1'b0;
            hdr_error      <= 1'b0;
            bit_cnt        <= '0;
            hdr_idx        <= 2'd0;
            wait_cnt       <= '0;
            shift          <= '0;
        end else begin
            latch_counter <= (state == IDLE) && start;
            count_valid   <= 1'b0;
            hdr_error     <= 1'b0;
            if ((state == IDLE) && start) begin
                counter_select <= sel;
            end
            case (state)
                LATCH: begin
                    wait_cnt <= '0;
                    hdr_idx  <= 2'd0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + WW'(1);
                end
                HDR: begin
                    hdr_idx <= hdr_idx + 2'd1;
                    bit_cnt <= '0;
                    if (hdr_bad) begin
                        hdr_error <= 1'b1;
                    end
                end
                DATA: begin
                    shift   <= {shift[LENGTH-2:0], data_in};
                    bit_cnt <= bit_cnt + BW'(1);
                    if (last_bit) begin
                        count       <= {shift[LENGTH-2:0], data_in};
                        count_sel   <= counter_select;
                        count_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
